sprite_plotter: RTL and testbench

Drawing datapath that executes the per-object state commands issued by the game controller and reports completion back. Each accepted command erases or draws the bird or wall sprite by scanning it into the 160x120 VGA adapter, one pixel per clock. It returns a one-cycle `done` pulse (the controller's `finished_draw`) and a sticky `collision` flag. It sits between the game controller and the VGA adapter's `x`/`y`/`colour`/`plot` inputs.

---
 rtl/sprite_pkg.sv | 29 ++
 rtl/sprite_plotter_rect_scanner.sv | 39 +++
 rtl/sprite_plotter.sv | 165 ++++++++++++++++
 tb/tb_sprite_plotter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared opcodes, screen geometry and sprite sizes for the controller and the sprite plotter.
package sprite_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_ERASE_BIRD = 3'd1;
  localparam logic [2:0] OP_DRAW_BIRD  = 3'd2;
  localparam logic [2:0] OP_ERASE_WALL = 3'd3;
  localparam logic [2:0] OP_DRAW_WALL  = 3'd4;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int BIRD_X_DEF   = 20;
  localparam int BIRD_W_DEF   = 4;
  localparam int BIRD_H_DEF   = 4;
  localparam int WALL_W_DEF   = 8;
  localparam int GAP_H_DEF    = 32;
  localparam logic [2:0] BG_COLOUR_DEF = 3'b000;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCAN, ST_DONE} plot_state_t;

  function automatic logic op_is_bird(input logic [2:0] op);
    return (op == OP_ERASE_BIRD) || (op == OP_DRAW_BIRD);
  endfunction

  function automatic logic op_is_wall(input logic [2:0] op);
    return (op == OP_ERASE_WALL) || (op == OP_DRAW_WALL);
  endfunction

endpackage

// File: rtl/sprite_plotter_rect_scanner.sv
// Row-major dx/dy walker over a w x h box; exposes the coordinates the counters take next.
module rect_scanner (
  input  logic       clk,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] w,
  input  logic [7:0] h,
  output logic [7:0] nxt_dx,
  output logic [7:0] nxt_dy,
  output logic       last
);

  logic [7:0] dx;
  logic [7:0] dy;

  assign last = (dx == w - 8'd1) && (dy == h - 8'd1);

  always_comb begin
    nxt_dx = dx;
    nxt_dy = dy;
    if (start) begin
      nxt_dx = 8'd0;
      nxt_dy = 8'd0;
    end else if (step) begin
      if (dx == w - 8'd1) begin
        nxt_dx = 8'd0;
        nxt_dy = dy + 8'd1;
      end else begin
        nxt_dx = dx + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    dx <= nxt_dx;
    dy <= nxt_dy;
  end

endmodule

// File: rtl/sprite_plotter.sv
// Executes erase/draw commands for the bird and wall sprites, one VGA pixel per clock,
// and tracks bird collisions against the last drawn wall and the ground.
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int BIRD_X   = BIRD_X_DEF,
  parameter int BIRD_W   = BIRD_W_DEF,
  parameter int BIRD_H   = BIRD_H_DEF,
  parameter int WALL_W   = WALL_W_DEF,
  parameter int GAP_H    = GAP_H_DEF,
  parameter logic [2:0] BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done,
  output logic       collision
);

  localparam logic [8:0] SW9  = 9'(SCREEN_W);
  localparam logic [8:0] SH9  = 9'(SCREEN_H);
  localparam logic [8:0] BX9  = 9'(BIRD_X);
  localparam logic [8:0] BW9  = 9'(BIRD_W);
  localparam logic [8:0] BH9  = 9'(BIRD_H);
  localparam logic [8:0] WW9  = 9'(WALL_W);
  localparam logic [8:0] GH9  = 9'(GAP_H);

  plot_state_t state, next_state;

  logic [2:0] op_l;
  logic [6:0] bird_y_l;
  logic [7:0] wall_x_l;
  logic [6:0] gap_y_l;
  logic [2:0] colour_l;

  logic       wall_valid;
  logic [7:0] wall_x_g;
  logic [6:0] gap_y_g;

  logic       is_bird, is_wall, is_draw;
  logic [8:0] base_x, base_y, gap_lo, gap_hi;
  logic [7:0] box_w, box_h;
  logic [2:0] scan_colour;
  logic [7:0] nxt_dx, nxt_dy;
  logic       last;
  logic [8:0] px, py;
  logic       px_plot;
  logic       accept;
  logic       ground_hit, wall_hit;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_ready && cmd_valid;

  assign is_bird = op_is_bird(op_l);
  assign is_wall = op_is_wall(op_l);
  assign is_draw = (op_l == OP_DRAW_BIRD) || (op_l == OP_DRAW_WALL);

  assign base_x      = is_bird ? BX9 : {1'b0, wall_x_l};
  assign base_y      = is_bird ? {2'b0, bird_y_l} : 9'd0;
  assign box_w       = is_bird ? BW9[7:0] : WW9[7:0];
  assign box_h       = is_bird ? BH9[7:0] : SH9[7:0];
  assign scan_colour = is_draw ? colour_l : BG_COLOUR;

  rect_scanner u_scan (
    .clk    (clk),
    .start  (state == ST_LOAD),
    .step   (state == ST_SCAN),
    .w      (box_w),
    .h      (box_h),
    .nxt_dx (nxt_dx),
    .nxt_dy (nxt_dy),
    .last   (last)
  );

  // Pixel presented in the coming cycle: clip to the screen and cut out the wall opening.
  assign gap_lo  = {2'b0, gap_y_l};
  assign gap_hi  = gap_lo + GH9 - 9'd1;
  assign px      = base_x + {1'b0, nxt_dx};
  assign py      = base_y + {1'b0, nxt_dy};
  assign px_plot = (px < SW9) && (py < SH9) && !(is_wall && (py >= gap_lo) && (py <= gap_hi));

  // Collision terms use the bird latched with this command and the stored wall geometry.
  assign ground_hit = ({2'b0, bird_y_l} + BH9 - 9'd1) >= SH9;
  assign wall_hit   = wall_valid
                   && ({1'b0, wall_x_g} <= BX9 + BW9 - 9'd1)
                   && (BX9 <= {1'b0, wall_x_g} + WW9 - 9'd1)
                   && !(({2'b0, bird_y_l} >= {2'b0, gap_y_g})
                        && ({2'b0, bird_y_l} + BH9 - 9'd1 <= {2'b0, gap_y_g} + GH9 - 9'd1));

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (cmd_valid) next_state = (op_is_bird(cmd_op) || op_is_wall(cmd_op)) ? ST_LOAD : ST_DONE;
      ST_LOAD: next_state = ST_SCAN;
      ST_SCAN: if (last) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_l     <= cmd_op;
      bird_y_l <= bird_y;
      wall_x_l <= wall_x;
      gap_y_l  <= gap_y;
      colour_l <= colour_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wall_valid <= 1'b0;
      wall_x_g   <= 8'd0;
      gap_y_g    <= 7'd0;
      collision  <= 1'b0;
    end else if (state == ST_LOAD) begin
      if (op_l == OP_DRAW_WALL) begin
        wall_valid <= 1'b1;
        wall_x_g   <= wall_x_l;
        gap_y_g    <= gap_y_l;
      end
      if ((op_l == OP_DRAW_BIRD) && (ground_hit || wall_hit)) collision <= 1'b1;
    end
  end

  // Output register stage: VGA write port and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (next_state == ST_DONE);
      if (next_state == ST_SCAN) begin
        x      <= px[7:0];
        y      <= py[6:0];
        colour <= scan_colour;
        plot   <= px_plot;
      end else begin
        plot   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: commands push expected pixels and completions; a monitor checks them.
module tb_sprite_plotter;

  localparam int SW = 160, SH = 120, BX = 20, BW = 4, BH = 4, WW = 8, GH = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [6:0] bird_y = 7'd0;
  logic [7:0] wall_x = 8'd0;
  logic [6:0] gap_y = 7'd0;
  logic [2:0] colour_in = 3'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, done, collision;

  sprite_plotter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .bird_y(bird_y), .wall_x(wall_x), .gap_y(gap_y),
    .colour_in(colour_in), .x(x), .y(y), .colour(colour), .plot(plot),
    .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { int c; int px; int py; int col; } pix_t;
  typedef struct { int c; int coll; } done_t;
  pix_t  pixq[$];
  done_t dq[$];
  pix_t  mp;
  done_t md;

  // Reference state of the game world as the plotter should see it.
  bit wv_m;
  int wx_m, gy_m;
  int coll_m;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (pixq.size() > 0 && pixq[0].c == cyc) begin
        mp = pixq.pop_front();
        check("plot", int'(plot), 1);
        if (plot) check("pixel_xyc", int'({x, y, colour}), (mp.px << 10) | (mp.py << 3) | mp.col);
      end else if (plot) begin
        check("unexpected_plot", int'(plot), 0);
      end
      if (dq.size() > 0 && dq[0].c == cyc) begin
        md = dq.pop_front();
        check("done", int'(done), 1);
        check("collision_at_done", int'(collision), md.coll);
        check("pixels_left", pixq.size(), 0);
      end else if (done) begin
        check("unexpected_done", int'(done), 0);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (dq.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (dq.size() > 0) begin
      check("done_timeout", dq.size(), 0);
      pixq.delete();
      dq.delete();
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_plot", int'(plot), 0);
    check("rst_done", int'(done), 0);
    check("rst_collision", int'(collision), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_xyc", int'({x, y, colour}), 0);
    pixq.delete();
    dq.delete();
    wv_m = 1'b0; wx_m = 0; gy_m = 0; coll_m = 0;
    reset = 1'b0;
  endtask

  task automatic issue(input int op, input int by, input int wx, input int gy,
                       input int col, input int hold, input bit wait_done);
    int t, n, idx, bx0, by0, w, h, pxv, pyv, cv;
    bit bird, wall;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'(op); bird_y = 7'(by); wall_x = 8'(wx); gap_y = 7'(gy); colour_in = 3'(col);
    t = 0;
    while (!cmd_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", int'(cmd_ready), 1);
      cmd_valid = 1'b0;
      return;
    end
    n = cyc;
    bird = (op == 1 || op == 2);
    wall = (op == 3 || op == 4);
    if (bird || wall) begin
      bx0 = bird ? BX : wx;
      by0 = bird ? by : 0;
      w = bird ? BW : WW;
      h = bird ? BH : SH;
      cv = (op == 2 || op == 4) ? col : 0;
      idx = 0;
      for (int dy = 0; dy < h; dy++) begin
        for (int dx = 0; dx < w; dx++) begin
          pxv = bx0 + dx;
          pyv = by0 + dy;
          if (pxv < SW && pyv < SH && !(wall && pyv >= gy && pyv <= gy + GH - 1))
            pixq.push_back('{n + 2 + idx, pxv, pyv, cv});
          idx++;
        end
      end
      if (op == 2) begin
        if (by + BH - 1 >= SH) coll_m = 1;
        if (wv_m && wx_m <= BX + BW - 1 && BX <= wx_m + WW - 1 &&
            !(by >= gy_m && by + BH - 1 <= gy_m + GH - 1)) coll_m = 1;
      end
      if (op == 4) begin
        wv_m = 1'b1; wx_m = wx; gy_m = gy;
      end
      dq.push_back('{n + 2 + w * h, coll_m});
    end else begin
      dq.push_back('{n + 1, coll_m});
    end
    @(negedge clk);
    check("ready_busy", int'(cmd_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("ready_held_busy", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    if (op == 2) begin
      while (cyc < n + 2) @(negedge clk);
      check("collision_n2", int'(collision), coll_m);
    end
    if (wait_done) wait_idle();
  endtask

  initial begin
    wv_m = 1'b0; wx_m = 0; gy_m = 0; coll_m = 0;
    repeat (3) @(negedge clk);
    check("init_plot", int'(plot), 0);
    check("init_done", int'(done), 0);
    check("init_collision", int'(collision), 0);
    check("init_ready", int'(cmd_ready), 1);
    reset = 1'b0;

    issue(2, 50, 0, 0, 6, 0, 1);
    issue(4, 0, 156, 40, 5, 0, 1);
    issue(4, 0, 18, 60, 2, 0, 1);
    issue(2, 62, 0, 0, 7, 0, 1);
    issue(2, 117, 0, 0, 7, 0, 1);

    reset_dut();
    issue(4, 0, 18, 60, 1, 0, 1);
    issue(2, 30, 0, 0, 4, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 1);
    issue(6, 0, 0, 0, 0, 0, 1);
    issue(1, 30, 0, 0, 5, 10, 1);
    issue(3, 0, 18, 60, 3, 0, 1);

    reset_dut();
    for (int k = 0; k < 14; k++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 7)), 0, 1);
    end

    reset_dut();
    issue(4, 0, 18, 60, 2, 0, 0);
    repeat (100) @(negedge clk);
    reset_dut();
    issue(2, 30, 0, 0, 6, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
